// File: rtl/spi_slave_param.sv
// SPI slave bridging a serial master to the single-port RAM rx/tx handshake.
// Define SPI_SLAVE_PARITY_EN to append an even-parity bit to both directions.
module spi_slave_param #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              SS_n,
   input  logic              MOSI,
   input  logic              tx_valid,
   input  logic [DATA_W-1:0] tx_data,
   output logic              MISO,
   output logic              rx_valid,
   output logic [DATA_W+1:0] rx_data,
   output logic              busy,
   output logic              frame_err
);
   localparam int N  = DATA_W + 2;
`ifdef SPI_SLAVE_PARITY_EN
   localparam int FL  = N + 1;
   localparam int TXL = DATA_W + 1;
`else
   localparam int FL  = N;
   localparam int TXL = DATA_W;
`endif
   localparam int CW = $clog2(FL + 1);
   localparam int TW = $clog2(TXL + 1);

   typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;
   state_t state, state_nxt;

   logic [CW-1:0]  bit_cnt;
   logic [FL-2:0]  shreg;
   logic           done;
   logic           rd_pend;
   logic           rd_arm;
   logic [TXL-1:0] tx_sh;
   logic [TW-1:0]  tx_cnt;

   logic [FL-1:0]  full;
   logic [N-1:0]   fw;
   logic [1:0]     cmd;
   logic [TXL-1:0] tx_word;
   logic in_frame, bit_in, last_bit, cmd_ok, par_ok, frame_ok;
   logic tx_busy, tx_load, abort;

   assign busy = (state != IDLE);

   always_comb begin
      full     = {shreg, MOSI};
      fw       = full[FL-1 -: N];
      cmd      = fw[N-1:N-2];
      in_frame = (state != IDLE);
      bit_in   = in_frame && !done;
      last_bit = bit_in && (state != CHK_CMD) && (bit_cnt == CW'(FL-1));
      cmd_ok   = !cmd[1];
      case (state)
         READ_ADD:  cmd_ok = (cmd == 2'b10);
         READ_DATA: cmd_ok = (cmd == 2'b11);
         default:   cmd_ok = !cmd[1];
      endcase
`ifdef SPI_SLAVE_PARITY_EN
      par_ok  = ~^full;
      tx_word = {tx_data, ^tx_data};
`else
      par_ok  = 1'b1;
      tx_word = tx_data;
`endif
      frame_ok = last_bit && cmd_ok && par_ok;
      tx_busy  = (tx_cnt != '0);
      tx_load  = rd_arm && tx_valid && !SS_n;
      // A completed frame may still be cut short while the reply is shifting out
      abort    = in_frame && SS_n && !last_bit && (!done || tx_busy);
   end

   always_comb begin
      state_nxt = state;
      if (state == IDLE) begin
         if (!SS_n) state_nxt = CHK_CMD;
      end else if (SS_n) begin
         state_nxt = IDLE;
      end else if (state == CHK_CMD) begin
         if (!MOSI)        state_nxt = WRITE;
         else if (rd_pend) state_nxt = READ_DATA;
         else              state_nxt = READ_ADD;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         shreg     <= '0;
         done      <= 1'b0;
         rd_pend   <= 1'b0;
         rd_arm    <= 1'b0;
         tx_sh     <= '0;
         tx_cnt    <= '0;
         MISO      <= 1'b0;
         rx_valid  <= 1'b0;
         rx_data   <= '0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_nxt;
         rx_valid  <= frame_ok;
         frame_err <= abort || (last_bit && !frame_ok);

         if (state == IDLE) begin
            bit_cnt <= '0;
            done    <= 1'b0;
         end else if (bit_in) begin
            shreg   <= full[FL-2:0];
            bit_cnt <= bit_cnt + 1'b1;
            if (last_bit) done <= 1'b1;
         end

         if (frame_ok) begin
            rx_data <= fw;
            if (state == READ_ADD)       rd_pend <= 1'b1;
            else if (state == READ_DATA) rd_pend <= 1'b0;
         end

         if (state_nxt == IDLE) begin
            tx_cnt <= '0;
            MISO   <= 1'b0;
            rd_arm <= 1'b0;
         end else if (tx_load) begin
            MISO   <= tx_word[TXL-1];
            tx_sh  <= tx_word << 1;
            tx_cnt <= TW'(TXL-1);
            rd_arm <= 1'b0;
         end else if (tx_busy) begin
            MISO   <= tx_sh[TXL-1];
            tx_sh  <= tx_sh << 1;
            tx_cnt <= tx_cnt - 1'b1;
         end else begin
            MISO <= 1'b0;
            // Only a valid read-data frame arms the single reply load
            if (frame_ok && state == READ_DATA) rd_arm <= 1'b1;
         end
      end
   end
endmodule
